// File: rtl/dac_pkg.sv
// Shared constants and sample type for the I2S DAC path.
package dac_pkg;

    localparam int DAC_SAMPLE_WIDTH = 24;
    localparam int DAC_FRAME_BITS   = 48;

    typedef logic signed [23:0] dac_sample_t;

endpackage

// File: rtl/i2s_dac_transmitter.sv
// I2S stereo serialiser for an external audio DAC, clk is the bit clock.
// Define DAC_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit delay).
module i2s_dac_transmitter
    import dac_pkg::*;
#(
    parameter int WIDTH = DAC_SAMPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [WIDTH-1:0] left_data,
    input  logic [WIDTH-1:0] right_data,
    output logic             sclk,
    output logic             lrclk,
    output logic             sd
);

    localparam int FB = 2 * WIDTH;
    localparam int CW = $clog2(FB);
    localparam logic [CW-1:0] LAST = CW'(FB - 1);
    localparam logic [CW-1:0] HALF = CW'(WIDTH);

    logic [CW-1:0] c;
    logic [CW-1:0] c_next;
    logic [FB-1:0] shreg;
    logic          run;
    logic          lrclk_q;
    logic          sd_q;
    logic          capture;
`ifndef DAC_LEFT_JUSTIFIED_EN
    logic          pend;
`endif

    always_comb begin
        c_next  = (c == LAST) ? '0 : c + CW'(1);
        capture = (c_next == '0);
    end

    // Idle (enable low) is indistinguishable from reset state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c       <= LAST;
            shreg   <= '0;
            run     <= 1'b0;
            lrclk_q <= 1'b0;
            sd_q    <= 1'b0;
`ifndef DAC_LEFT_JUSTIFIED_EN
            pend    <= 1'b0;
`endif
        end else if (!enable) begin
            c       <= LAST;
            shreg   <= '0;
            run     <= 1'b0;
            lrclk_q <= 1'b0;
            sd_q    <= 1'b0;
`ifndef DAC_LEFT_JUSTIFIED_EN
            pend    <= 1'b0;
`endif
        end else begin
            run     <= 1'b1;
            c       <= c_next;
            lrclk_q <= (c_next >= HALF);
            if (capture) begin
`ifdef DAC_LEFT_JUSTIFIED_EN
                shreg <= {left_data, right_data} << 1;
                sd_q  <= left_data[WIDTH-1];
`else
                // Previous right LSB goes out first; this frame's is held back.
                shreg <= {left_data, right_data};
                sd_q  <= pend;
                pend  <= right_data[0];
`endif
            end else begin
                sd_q  <= shreg[FB-1];
                shreg <= {shreg[FB-2:0], 1'b0};
            end
        end
    end

    // run only changes while clk is high, so this AND cannot glitch.
    assign sclk  = ~clk & run;
    assign lrclk = lrclk_q;
    assign sd    = sd_q;

endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Scoreboard bench for i2s_dac_transmitter with a frame-level reference model.
module tb_i2s_dac_transmitter;
    import dac_pkg::*;

    localparam int W  = DAC_SAMPLE_WIDTH;
    localparam int FB = DAC_FRAME_BITS;

    typedef struct {
        logic lr;
        logic sd;
        int   pos;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        enable;
    dac_sample_t left_data;
    dac_sample_t right_data;
    logic        sclk;
    logic        lrclk;
    logic        sd;

    exp_t q[$];
    logic model_pend;
    int   errors;
    int   checks;

    i2s_dac_transmitter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .left_data  (left_data),
        .right_data (right_data),
        .sclk       (sclk),
        .lrclk      (lrclk),
        .sd         (sd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bit stream of one frame, derived from the slot layout.
    task automatic push_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        exp_t e;
        for (int k = 0; k < FB; k++) begin
            e.pos = k;
            e.lr  = (k >= W);
`ifdef DAC_LEFT_JUSTIFIED_EN
            if (k < W) e.sd = l[W-1-k];
            else       e.sd = r[FB-1-k];
`else
            if (k == 0)       e.sd = model_pend;
            else if (k <= W)  e.sd = l[W-k];
            else              e.sd = r[FB-k];
`endif
            q.push_back(e);
        end
`ifndef DAC_LEFT_JUSTIFIED_EN
        model_pend = r[0];
`endif
    endtask

    task automatic check(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per enabled edge, zeros otherwise.
    initial begin
        logic e;
        exp_t x;
        forever begin
            @(posedge clk);
            e = enable && rstn;
            #1;
            if (e) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL underflow: no expected bit at %0t", $time);
                end else begin
                    x = q.pop_front();
                    check($sformatf("lrclk pos%0d", x.pos), lrclk, x.lr);
                    check($sformatf("sd pos%0d", x.pos), sd, x.sd);
                end
            end else begin
                check("idle lrclk", lrclk, 1'b0);
                check("idle sd", sd, 1'b0);
            end
            @(negedge clk);
            #1;
            check("sclk", sclk, e && rstn);
        end
    end

    // Runs one frame from its capture edge; optional scramble, drop or reset.
    task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r,
                         input bit scramble, input int cut, input int rst_at);
        enable     = 1'b1;
        left_data  = l;
        right_data = r;
        push_frame(l, r);
        for (int k = 0; k < FB; k++) begin
            @(posedge clk);
            if (k == rst_at) begin
                #2;
                rstn = 1'b0;
                #1;
                check("async lrclk", lrclk, 1'b0);
                check("async sd", sd, 1'b0);
                q.delete();
                model_pend = 1'b0;
                @(negedge clk);
                @(posedge clk);
                @(negedge clk);
                rstn = 1'b1;
                return;
            end
            @(negedge clk);
            if (scramble && k >= 10) begin
                left_data  = $urandom;
                right_data = $urandom;
            end
            if (k == cut) begin
                enable = 1'b0;
                q.delete();
                model_pend = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors     = 0;
        checks     = 0;
        model_pend = 1'b0;
        rstn       = 1'b0;
        enable     = 1'b1;
        left_data  = '0;
        right_data = '0;
        repeat (3) @(negedge clk);
        check("reset lrclk", lrclk, 1'b0);
        check("reset sd", sd, 1'b0);
        check("reset sclk", sclk, 1'b0);
        rstn = 1'b1;

        frame(24'hA5A5A5, 24'h3C3C3C, 1'b0, -1, -1);
        frame(24'h123456, 24'h654321, 1'b1, -1, -1);
        frame(24'h800000, 24'h7FFFFF, 1'b0, -1, -1);
        frame(24'h000000, 24'h000001, 1'b0, -1, -1);
        for (int i = 0; i < 5; i++)
            frame(W'($urandom), W'($urandom), 1'b1, -1, -1);

        frame(W'($urandom), W'($urandom), 1'b0, 30, -1);
        repeat (3) @(negedge clk);
        frame(W'($urandom), W'($urandom | 1), 1'b0, -1, -1);

        frame(W'($urandom), W'($urandom), 1'b0, -1, 15);
        frame(W'($urandom), W'($urandom | 1), 1'b0, -1, -1);
        frame(W'($urandom), W'($urandom), 1'b1, -1, -1);

        enable = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d entries remain, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
